// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared audio definitions used by the synthesizer output path and the I2S
// transmitter: default slot/sample widths and the stereo sample types.
// No ports (package).
// -----------------------------------------------------------------------------
package audio_pkg;

  localparam int I2S_SLOT_WIDTH = 32;
  localparam int AUDIO_WIDTH    = 24;

  typedef logic signed [AUDIO_WIDTH-1:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

endpackage

// File: rtl/i2s_clkgen.sv
// -----------------------------------------------------------------------------
// i2s_clkgen
// Bit-clock and word-select generator for the I2S transmitter. Divides
// AUDIO_CLK down to BCLK, tracks the bit position within the stereo frame and
// drives LRCK, which only changes on falling BCLK.
//
// Ports:
//   AUDIO_CLK    in   sole clock
//   reset_reg_N  in   asynchronous active-low reset
//   bclk         out  bit clock (registered)
//   lrck         out  word select, 0 = left, 1 = right (registered)
//   bit_cnt      out  current bit position within the frame
//   fall         out  strobe: BCLK falls on this clock edge
//   frame_load   out  strobe: this falling edge wraps bit_cnt to 0
// -----------------------------------------------------------------------------
module i2s_clkgen #(
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_DIV   = 4,
  parameter int CNT_W      = $clog2(2 * SLOT_WIDTH)
) (
  input  logic             AUDIO_CLK,
  input  logic             reset_reg_N,
  output logic             bclk,
  output logic             lrck,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             fall,
  output logic             frame_load
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0] SLOT_FIRST = CNT_W'(SLOT_WIDTH);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;
  logic [CNT_W-1:0] bit_cnt_nxt;

  assign wrap        = (div_cnt == DIV_LAST);
  assign fall        = wrap && bclk;
  assign frame_load  = fall && (bit_cnt == CNT_LAST);
  assign bit_cnt_nxt = frame_load ? '0 : bit_cnt + 1'b1;

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values, regardless of statement order.
  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= CNT_LAST;
      lrck    <= 1'b1;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
      if (bclk) begin
        bit_cnt <= bit_cnt_nxt;
        lrck    <= (bit_cnt_nxt >= SLOT_FIRST);
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// -----------------------------------------------------------------------------
// i2s_dac_tx
// Audio output stage: buffers one pending stereo pair from the synthesizer and
// serialises it as a Philips I2S stream (one-bit data delay after LRCK, MSB
// first, left slot while LRCK=0). Single clock domain (AUDIO_CLK).
//
// Build option: define I2S_UNDERRUN_MUTE_EN to play silence for a frame that
// starts with no pending pair; otherwise the previous pair repeats.
//
// Ports:
//   AUDIO_CLK     in   sole clock
//   reset_reg_N   in   asynchronous active-low reset
//   lsound_in     in   left sample, signed, DATA_WIDTH bits
//   rsound_in     in   right sample, signed, DATA_WIDTH bits
//   sample_valid  in   one-cycle strobe capturing lsound_in/rsound_in
//   i2s_bclk      out  bit clock
//   i2s_lrck      out  word select
//   i2s_dacdat    out  serial data
//   frame_start   out  one-cycle pulse at each frame load
//   underrun      out  one-cycle pulse: frame loaded with nothing pending
//   overrun       out  one-cycle pulse: pending pair overwritten unused
// -----------------------------------------------------------------------------
module i2s_dac_tx
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = AUDIO_WIDTH,
  parameter int SLOT_WIDTH = I2S_SLOT_WIDTH,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  AUDIO_CLK,
  input  logic                  reset_reg_N,
  input  logic [DATA_WIDTH-1:0] lsound_in,
  input  logic [DATA_WIDTH-1:0] rsound_in,
  input  logic                  sample_valid,
  output logic                  i2s_bclk,
  output logic                  i2s_lrck,
  output logic                  i2s_dacdat,
  output logic                  frame_start,
  output logic                  underrun,
  output logic                  overrun
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int PAD        = SLOT_WIDTH - DATA_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

  logic [CNT_W-1:0]      bit_cnt;
  logic                  fall;
  logic                  frame_load;

  logic [DATA_WIDTH-1:0] pend_l, pend_r;
  logic                  pend_full;
  logic [DATA_WIDTH-1:0] act_l, act_r;
  logic [FRAME_BITS-1:0] frame_vec;

  i2s_clkgen #(
    .SLOT_WIDTH (SLOT_WIDTH),
    .BCLK_DIV   (BCLK_DIV),
    .CNT_W      (CNT_W)
  ) u_clkgen (
    .AUDIO_CLK   (AUDIO_CLK),
    .reset_reg_N (reset_reg_N),
    .bclk        (i2s_bclk),
    .lrck        (i2s_lrck),
    .bit_cnt     (bit_cnt),
    .fall        (fall),
    .frame_load  (frame_load)
  );

  // Active frame laid out with the left MSB in the top bit.
  assign frame_vec = {act_l, {PAD{1'b0}}, act_r, {PAD{1'b0}}};

  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      pend_l      <= '0;
      pend_r      <= '0;
      pend_full   <= 1'b0;
      act_l       <= '0;
      act_r       <= '0;
      i2s_dacdat  <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_start <= frame_load;
      underrun    <= frame_load && !pend_full;
      // A capture coinciding with a load refills a slot that is being emptied.
      overrun     <= sample_valid && pend_full && !frame_load;

      if (frame_load) begin
        if (pend_full) begin
          act_l <= pend_l;
          act_r <= pend_r;
        end
`ifdef I2S_UNDERRUN_MUTE_EN
        else begin
          act_l <= '0;
          act_r <= '0;
        end
`endif
      end

      if (sample_valid) begin
        pend_l    <= lsound_in;
        pend_r    <= rsound_in;
        pend_full <= 1'b1;
      end else if (frame_load) begin
        pend_full <= 1'b0;
      end

      // Bit p of the frame carries frame element p-1 (one-bit I2S delay). On
      // the wrapping edge bit_cnt is still the last position, which selects
      // frame_vec[0]: trailing right-slot padding of the outgoing frame.
      if (fall) begin
        i2s_dacdat <= frame_vec[CNT_LAST - bit_cnt];
      end
    end
  end

endmodule
